// File: rtl/baser_257b_pkg.sv
// Shared constants, slot type and helpers for the 256b/257b transmit transcoder.
// Block-type list and error block mirror what the receive-side 257b checker expects.
package baser_257b_pkg;

  localparam int DATA_WIDTH    = 64;
  localparam int SH_WIDTH      = 1;
  localparam int TC_DATA_WIDTH = 4 * DATA_WIDTH;
  localparam int TC_WIDTH      = TC_DATA_WIDTH + SH_WIDTH;
  localparam int CODED_WIDTH   = DATA_WIDTH + 2;
  localparam int NUM_SLOTS     = 4;
  localparam int CMP_WIDTH     = DATA_WIDTH - 4;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int NUM_TYPES = 15;
  localparam logic [NUM_TYPES*8-1:0] VALID_TYPES = {
    8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87,
    8'h78, 8'h66, 8'h55, 8'h4B, 8'h33, 8'h2D, 8'h1E
  };

  localparam logic [7:0]            ERR_TYPE  = 8'h1E;
  localparam logic [DATA_WIDTH-1:0] ERR_BLOCK = {{8{7'h1E}}, ERR_TYPE};

  typedef struct packed {
    logic                  is_data;
    logic [DATA_WIDTH-1:0] payload;
  } slot_t;

  function automatic logic type_is_valid(input logic [7:0] blk_type);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if (VALID_TYPES[i*8 +: 8] == blk_type) hit = 1'b1;
    end
    return hit;
  endfunction

  // The low type nibble is implied by the high one for every legal type.
  function automatic logic [3:0] compress_type(input logic [7:0] blk_type);
    return 4'(blk_type >> 4);
  endfunction

endpackage

// File: rtl/baser_66b_block_classifier.sv
// Combinational 66b block check: data/control decode, type validation, error-block substitution.
module baser_66b_block_classifier
  import baser_257b_pkg::*;
(
  input  logic [CODED_WIDTH-1:0] block,
  output logic                   is_data,
  output logic                   is_valid,
  output logic [DATA_WIDTH-1:0]  payload
);

  logic [1:0]            sh;
  logic [DATA_WIDTH-1:0] raw;

  assign sh  = block[1:0];
  assign raw = block[CODED_WIDTH-1:2];

  always_comb begin
    is_data  = (sh == SH_DATA);
    is_valid = is_data || ((sh == SH_CTRL) && type_is_valid(raw[7:0]));
    payload  = is_valid ? raw : ERR_BLOCK;
  end

endmodule

// File: rtl/baser_257b_transcoder.sv
// Groups four 66b blocks into one 257b word, registered one cycle after the 4th accept; only the 4th block stalls on a full output.
// Statistics counters exist only when BASER_257B_TX_STATS_EN is defined; otherwise the count ports read 0.
module baser_257b_transcoder
  import baser_257b_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [CODED_WIDTH-1:0] i_tx_coded,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [TC_WIDTH-1:0]    o_tx_coded,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CNT_WIDTH-1:0]   o_block_count,
  output logic [CNT_WIDTH-1:0]   o_data_count,
  output logic [CNT_WIDTH-1:0]   o_ctrl_count,
  output logic [CNT_WIDTH-1:0]   o_inv_block_count
);

  logic [1:0]            idx;
  slot_t [2:0]           acc;
  slot_t                 cur;
  logic                  cur_is_data;
  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] cur_payload;
  logic                  accept;
  logic                  last;
  logic                  load;
  slot_t [3:0]           grp;
  logic [NUM_SLOTS-1:0]  data_map;
  logic                  all_data;
  logic [TC_WIDTH-1:0]   packed_word;
  logic [8:0]            pos;
  logic                  seen_ctrl;

  baser_66b_block_classifier u_classifier (
    .block    (i_tx_coded),
    .is_data  (cur_is_data),
    .is_valid (cur_valid),
    .payload  (cur_payload)
  );

  assign cur.is_data = cur_is_data;
  assign cur.payload = cur_payload;

  assign last    = (idx == 2'd3);
  assign o_ready = i_rst && !(last && o_valid && !i_ready);
  assign accept  = i_valid && o_ready;
  assign load    = accept && last;

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      idx <= '0;
      acc <= '0;
    end else if (accept) begin
      idx <= idx + 2'd1;
      for (int k = 0; k < 3; k++) begin
        if (idx == 2'(k)) acc[k] <= cur;
      end
    end
  end

  // The 4th block is packed straight from the input so the word loads on its accept edge.
  always_comb begin
    grp = {cur, acc};
    data_map = '0;
    for (int k = 0; k < NUM_SLOTS; k++) data_map[k] = grp[k].is_data;
    all_data = &data_map;
  end

  always_comb begin
    packed_word = '0;
    pos         = 9'd5;
    seen_ctrl   = 1'b0;
    if (all_data) begin
      packed_word = {grp[3].payload, grp[2].payload, grp[1].payload, grp[0].payload, 1'b1};
    end else begin
      packed_word[4:0] = {data_map, 1'b0};
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (!grp[k].is_data && !seen_ctrl) begin
          packed_word[pos +: CMP_WIDTH] = {grp[k].payload[DATA_WIDTH-1:8],
                                           compress_type(grp[k].payload[7:0])};
          pos       = pos + 9'(CMP_WIDTH);
          seen_ctrl = 1'b1;
        end else begin
          packed_word[pos +: DATA_WIDTH] = grp[k].payload;
          pos = pos + 9'(DATA_WIDTH);
        end
      end
    end
  end

  // A reload in the drain cycle keeps o_valid high with the new word.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      o_valid    <= 1'b0;
      o_tx_coded <= '0;
    end else if (load) begin
      o_valid    <= 1'b1;
      o_tx_coded <= packed_word;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

`ifdef BASER_257B_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      o_block_count     <= '0;
      o_data_count      <= '0;
      o_ctrl_count      <= '0;
      o_inv_block_count <= '0;
    end else begin
      if (load) begin
        o_block_count <= o_block_count + CNT_WIDTH'(1);
        if (all_data) o_data_count <= o_data_count + CNT_WIDTH'(1);
        else          o_ctrl_count <= o_ctrl_count + CNT_WIDTH'(1);
      end
      if (accept && !cur_valid) o_inv_block_count <= o_inv_block_count + CNT_WIDTH'(1);
    end
  end
`else
  logic stats_unused;
  assign stats_unused      = cur_valid;
  assign o_block_count     = '0;
  assign o_data_count      = '0;
  assign o_ctrl_count      = '0;
  assign o_inv_block_count = '0;
`endif

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Directed plus randomized bench for the 257b transcoder against a bit-position reference model.
module tb_baser_257b_transcoder;

  logic        clk;
  logic        i_rst;
  logic [65:0] i_tx_coded;
  logic        i_valid;
  logic        o_ready;
  logic [256:0] o_tx_coded;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_block_count;
  logic [31:0] o_data_count;
  logic [31:0] o_ctrl_count;
  logic [31:0] o_inv_block_count;

  baser_257b_transcoder dut (
    .clk               (clk),
    .i_rst             (i_rst),
    .i_tx_coded        (i_tx_coded),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .o_tx_coded        (o_tx_coded),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_block_count     (o_block_count),
    .o_data_count      (o_data_count),
    .o_ctrl_count      (o_ctrl_count),
    .o_inv_block_count (o_inv_block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit rand_rdy = 0;

  logic [65:0]  grp_q[$];
  logic [256:0] exp_q[$];
  logic [256:0] got_q[$];
  int m_blocks = 0, m_data = 0, m_ctrl = 0, m_inv = 0;

  logic [7:0] legal_types [15] = '{8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
                                   8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  // Words leave when o_valid && i_ready holds across the next rising edge.
  always @(negedge clk) begin
    if (i_rst && o_valid && i_ready) got_q.push_back(o_tx_coded);
  end

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void sanitize(input logic [65:0] b, output bit is_data, output bit inv,
                                   output logic [63:0] pl);
    logic [7:0] t;
    t = b[9:2];
    is_data = (b[1:0] == 2'b01);
    inv = 0;
    if (is_data) pl = b[65:2];
    else if (b[1:0] == 2'b10 && (t inside {8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
                                           8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF}))
      pl = b[65:2];
    else begin
      inv = 1;
      pl = 64'h1E;
      for (int i = 0; i < 8; i++) pl = pl | (64'h1E << (8 + 7 * i));
    end
  endfunction

  function automatic logic [256:0] model_word(input logic [65:0] g[4]);
    bit d[4];
    bit inv;
    logic [63:0] p[4];
    logic [256:0] w;
    int f, start;
    f = -1;
    for (int k = 0; k < 4; k++) begin
      sanitize(g[k], d[k], inv, p[k]);
      if (!d[k] && f < 0) f = k;
    end
    w = '0;
    if (f < 0) begin
      w = 257'(1);
      for (int k = 0; k < 4; k++) w = w | (257'(p[k]) << (1 + 64 * k));
    end else begin
      for (int k = 0; k < 4; k++) if (d[k]) w = w | (257'(1) << (1 + k));
      for (int k = 0; k < 4; k++) begin
        start = 5 + 64 * k - ((k > f) ? 4 : 0);
        if (k == f) w = w | ((((257'(p[k]) >> 8) << 4) | 257'(p[k][7:4])) << start);
        else        w = w | (257'(p[k]) << start);
      end
    end
    return w;
  endfunction

  task automatic model_push(input logic [65:0] b);
    bit d, inv, all_d;
    logic [63:0] p;
    logic [65:0] g[4];
    sanitize(b, d, inv, p);
    if (inv) m_inv++;
    grp_q.push_back(b);
    if (grp_q.size() == 4) begin
      all_d = 1;
      for (int k = 0; k < 4; k++) begin
        g[k] = grp_q[k];
        if (g[k][1:0] != 2'b01) all_d = 0;
      end
      exp_q.push_back(model_word(g));
      m_blocks++;
      if (all_d) m_data++;
      else       m_ctrl++;
      grp_q.delete();
    end
  endtask

  task automatic send(input logic [65:0] b);
    int n;
    n = 0;
    i_tx_coded = b;
    i_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (o_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", o_ready, 1);
        i_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    end
    i_valid = 1'b0;
    if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    model_push(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_counts(input string tag);
`ifdef BASER_257B_TX_STATS_EN
    chk({tag, "_blk_cnt"},  o_block_count,     m_blocks);
    chk({tag, "_data_cnt"}, o_data_count,      m_data);
    chk({tag, "_ctrl_cnt"}, o_ctrl_count,      m_ctrl);
    chk({tag, "_inv_cnt"},  o_inv_block_count, m_inv);
`else
    chk({tag, "_blk_cnt"},  o_block_count,     0);
    chk({tag, "_data_cnt"}, o_data_count,      0);
    chk({tag, "_ctrl_cnt"}, o_ctrl_count,      0);
    chk({tag, "_inv_cnt"},  o_inv_block_count, 0);
`endif
  endtask

  function automatic logic [65:0] data_blk();
    return {$urandom, $urandom, 2'b01};
  endfunction

  function automatic logic [65:0] ctrl_blk(input logic [7:0] t);
    return {$urandom, 24'($urandom), t, 2'b10};
  endfunction

  function automatic logic [65:0] rand_blk();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5)  return data_blk();
    if (r < 8)  return ctrl_blk(legal_types[$urandom_range(0, 14)]);
    if (r == 8) return ctrl_blk(8'($urandom));
    return {$urandom, $urandom, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00};
  endfunction

  logic [256:0] e1;
  logic [65:0]  b8;

  initial begin
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_tx_coded = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_word", o_tx_coded, 0);
    chk_counts("rst");
    i_rst = 1'b1;
    idle(1);
    chk("ready_after_rst", o_ready, 1);

    // all-data group
    for (int k = 0; k < 3; k++) send({{8{8'hAA}}, 2'b01});
    chk("lat_not_yet", o_valid, 0);
    send({{8{8'hAA}}, 2'b01});
    chk("lat_valid", o_valid, 1);
    idle(3);
    e1 = {{32{8'hAA}}, 1'b1};
    chk("all_data_word", o_tx_coded, e1);
    chk("valid_drained", o_valid, 0);
    chk_words("all_data");
    chk_counts("all_data");

    // control first, then three data blocks
    send(ctrl_blk(8'h78));
    for (int k = 0; k < 3; k++) send(data_blk());
    idle(3);
    chk("c78_hdr", o_tx_coded[4:0], 5'b11100);
    chk("c78_nibble", o_tx_coded[8:5], 4'h7);
    chk_words("c78");

    // D, C(FF), D, C(87)
    send(data_blk());
    send(ctrl_blk(8'hFF));
    send(data_blk());
    send(ctrl_blk(8'h87));
    idle(3);
    chk("mix_hdr", o_tx_coded[4:0], 5'b01010);
    chk("mix_nibble", o_tx_coded[72:69], 4'hF);
    chk("mix_type3", o_tx_coded[200:193], 8'h87);
    chk_words("mix");
    chk_counts("mix");

    // invalid header and illegal control type
    send({$urandom, $urandom, 2'b11});
    send(data_blk());
    send(ctrl_blk(8'h4C));
    send(data_blk());
    idle(3);
    chk("inv_hdr", o_tx_coded[4:0], 5'b10100);
    chk("inv_nibble", o_tx_coded[8:5], 4'h1);
    chk_words("inv");
    chk_counts("inv");

    // output stalled across two groups
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(rand_blk());
    chk("stall_loaded", o_valid, 1);
    for (int k = 0; k < 2; k++) begin
      send(rand_blk());
      chk("stall_rdy_early", o_ready, 1);
    end
    send(rand_blk());
    chk("stall_rdy_8th", o_ready, 0);
    b8 = rand_blk();
    i_tx_coded = b8;
    i_valid = 1'b1;
    idle(3);
    chk("stall_rdy_held", o_ready, 0);
    chk("stall_hold_word", o_tx_coded, exp_q[0]);
    chk("stall_no_out", got_q.size(), 0);
    i_ready = 1'b1;
    send(b8);
    idle(3);
    chk_words("stall");
    chk_counts("stall");

    // randomized traffic with random back-pressure
    rand_rdy = 1;
    for (int g = 0; g < 12; g++) begin
      for (int k = 0; k < 4; k++) begin
        send(rand_blk());
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_rdy = 0;
    i_ready = 1'b1;
    idle(6);
    chk_words("random");
    chk_counts("random");

    // reset in the middle of a group
    send(rand_blk());
    send(rand_blk());
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    grp_q.delete();
    m_blocks = 0; m_data = 0; m_ctrl = 0; m_inv = 0;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ready", o_ready, 0);
    chk("mid_rst_word", o_tx_coded, 0);
    chk_counts("mid_rst");
    i_rst = 1'b1;
    idle(1);
    send(ctrl_blk(8'h33));
    for (int k = 0; k < 3; k++) send(rand_blk());
    idle(3);
    chk_words("post_rst");
    chk_counts("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
